// File: rtl/lu_pipe.sv
// WIDTH-bit bitwise logic unit with accumulator and a valid/ready registered output stage.
// Define LU_FLAGS_EN to register zero/odd-parity flags alongside the result.
module lu_pipe #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             use_acc,
  input  logic             acc_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_p
);

  typedef enum logic [3:0] {
    OP_ZERO  = 4'h0, OP_A    = 4'h1, OP_NA   = 4'h2, OP_AND  = 4'h3,
    OP_NAND_B = 4'h4, OP_OR  = 4'h5, OP_NAOR = 4'h6, OP_XNOR = 4'h7,
    OP_XOR   = 4'h8, OP_NAND = 4'h9, OP_NOR  = 4'hA, OP_B    = 4'hB,
    OP_ANDNB = 4'hC, OP_ONES = 4'hD, OP_SHL  = 4'hE, OP_SHR  = 4'hF
  } op_e;

  logic [WIDTH-1:0] y_q, acc_q;
  logic             valid_q;
  logic [WIDTH-1:0] a_op, r;
  logic             accept;
  op_e              op_s;

  assign op_s     = op_e'(op);
  assign a_op     = use_acc ? acc_q : a;
  assign in_ready = !rst && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    r = '0;
    case (op_s)
      OP_ZERO:   r = '0;
      OP_A:      r = a_op;
      OP_NA:     r = ~a_op;
      OP_AND:    r = a_op & b;
      OP_NAND_B: r = ~a_op & b;
      OP_OR:     r = a_op | b;
      OP_NAOR:   r = ~a_op | b;
      OP_XNOR:   r = ~(a_op ^ b);
      OP_XOR:    r = a_op ^ b;
      OP_NAND:   r = ~(a_op & b);
      OP_NOR:    r = ~(a_op | b);
      OP_B:      r = b;
      OP_ANDNB:  r = a_op & ~b;
      OP_ONES:   r = '1;
      OP_SHL:    r = {a_op[WIDTH-2:0], 1'b0};
      OP_SHR:    r = {1'b0, a_op[WIDTH-1:1]};
      default:   r = '0;
    endcase
  end

  // Accept takes priority over delivery so a simultaneous accept+deliver keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      acc_q   <= ACC_INIT;
    end else if (accept) begin
      y_q     <= r;
      valid_q <= 1'b1;
      if (acc_we) acc_q <= r;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign acc       = acc_q;

`ifdef LU_FLAGS_EN
  logic z_q, p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      p_q <= 1'b0;
    end else if (accept) begin
      z_q <= (r == '0);
      p_q <= ^r;
    end
  end

  assign flag_z = z_q;
  assign flag_p = p_q;
`else
  assign flag_z = 1'b0;
  assign flag_p = 1'b0;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// Scoreboard bench for lu_pipe (WIDTH=8, ACC_INIT=0): driver pushes reference results,
// monitor pops and compares on every delivery.
module tb_lu_pipe;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, use_acc, acc_we, out_valid, out_ready;
  logic [7:0] a, b, y, acc;
  logic [3:0] op;
  logic       flag_z, flag_p;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what the DUT should show before the coming edge.
  bit         m_valid = 0;
  logic [7:0] m_acc   = 8'h00;
  logic [7:0] m_y     = 8'h00;
  logic       m_z     = 1'b0;
  logic       m_p     = 1'b0;

  lu_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_we(acc_we),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .acc(acc),
    .flag_z(flag_z), .flag_p(flag_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] ref_lu(input logic [3:0] o, input logic [7:0] x, input logic [7:0] w);
    int unsigned A = x;
    int unsigned B = w;
    int unsigned nA = 255 - A;
    int unsigned nB = 255 - B;
    int unsigned res;
    case (o)
      4'h0: res = 0;
      4'h1: res = A;
      4'h2: res = nA;
      4'h3: res = A & B;
      4'h4: res = nA & B;
      4'h5: res = A | B;
      4'h6: res = nA | B;
      4'h7: res = 255 - (A ^ B);
      4'h8: res = A ^ B;
      4'h9: res = 255 - (A & B);
      4'hA: res = 255 - (A | B);
      4'hB: res = B;
      4'hC: res = A & nB;
      4'hD: res = 255;
      4'hE: res = (A * 2) % 256;
      default: res = A / 2;
    endcase
    return res[7:0];
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] v);
    exp_t e;
    e.y = v;
`ifdef LU_FLAGS_EN
    e.z = (v == 8'h00);
    e.p = ($countones(v) % 2) == 1;
`else
    e.z = 1'b0;
    e.p = 1'b0;
`endif
    return e;
  endfunction

  // One clock cycle: drive, check pre-edge state against the model, then advance the model.
  task automatic step(input logic r, input logic iv, input logic orr,
                      input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top,
                      input logic ua, input logic aw,
                      input bit ovr, input logic [7:0] ovv);
    logic       exp_rdy;
    logic [7:0] res;
    exp_t       e;
    @(negedge clk);
    rst = r; in_valid = iv; out_ready = orr;
    a = ta; b = tb; op = top; use_acc = ua; acc_we = aw;
    #1;
    exp_rdy = !r && (!m_valid || orr);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("acc", {24'd0, acc}, {24'd0, m_acc});
    if (!m_valid) begin
      check("y_hold", {24'd0, y}, {24'd0, m_y});
      check("flags_hold", {30'd0, flag_z, flag_p}, {30'd0, m_z, m_p});
    end
    if (r) begin
      m_valid = 0; m_acc = 8'h00; m_y = 8'h00; m_z = 1'b0; m_p = 1'b0;
      exp_q.delete();
    end else if (iv && exp_rdy) begin
      res = ref_lu(top, ua ? m_acc : ta, tb);
      if (ovr) res = ovv;
      e = mk_exp(res);
      exp_q.push_back(e);
      if (aw) m_acc = res;
      m_y = e.y; m_z = e.z; m_p = e.p;
      m_valid = 1;
    end else if (orr) begin
      m_valid = 0;
    end
  endtask

  // Monitor: just before each rising edge, consume a delivered result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_delivery", {24'd0, y}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("y", {24'd0, y}, {24'd0, e.y});
          check("flags", {30'd0, flag_z, flag_p}, {30'd0, e.z, e.p});
        end
      end
    end
  end

  logic [7:0] op_tab [16];

  initial begin
    op_tab = '{8'h00, 8'hC3, 8'h3C, 8'h03, 8'h0C, 8'hCF, 8'h3F, 8'h33,
               8'hCC, 8'hFC, 8'h30, 8'h0F, 8'hC0, 8'hFF, 8'h86, 8'h61};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; use_acc = 1'b0; acc_we = 1'b0;

    step(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Opcode sweep against the fixed table.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 8'hC3, 8'h0F, 4'(i), 0, 0, 1, op_tab[i]);
    end
    step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Accumulate back-to-back.
    step(0, 1, 1, 8'h00, 8'h01, 4'h5, 0, 1, 1, 8'h01);
    step(0, 1, 1, 8'hFF, 8'h80, 4'h5, 1, 1, 1, 8'h81);
    step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Backpressure: result held for 3 cycles, then delivered as the next op is accepted.
    step(0, 1, 0, 8'h12, 8'h34, 4'h8, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hAA, 8'h55, 4'h5, 0, 1, 0, 8'h00);
    step(0, 1, 1, 8'hAA, 8'h55, 4'h5, 0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Flag patterns.
    step(0, 1, 1, 8'h55, 8'h55, 4'h8, 0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h01, 8'h00, 4'h1, 0, 0, 1, 8'h01);
    step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Reset while a result is pending.
    step(0, 1, 0, 8'h0F, 8'hF0, 4'h5, 0, 1, 0, 8'h00);
    step(1, 1, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);
    step(1, 1, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);

    // Random valid/ready traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 65), 8'($urandom), 8'($urandom),
           4'($urandom), 1'($urandom), 1'($urandom), 0, 8'h00);
    end

    // Drain and confirm nothing was lost.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 8'h00, 4'h0, 0, 0, 0, 8'h00);
    check("drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
